// File: rtl/dram_cmd_pkg.sv
// Shared types, address field layout, op codes and timing defaults for the DRAM command path.
package dram_cmd_pkg;

    // DIMM command encoding driven on cmd_type
    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD0  = 3'd3,
        CMD_RD1  = 3'd4,
        CMD_WR0  = 3'd5,
        CMD_WR1  = 3'd6,
        CMD_PRE  = 3'd7
    } cmd_t;

    // Physical address layout
    localparam int unsigned ADDR_W   = 36;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned CH_BIT   = 6;
    localparam int unsigned BG_LSB   = 7;
    localparam int unsigned BG_W     = 3;
    localparam int unsigned BANK_LSB = 10;
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned COL_LSB  = 12;
    localparam int unsigned COL_W    = 6;
    localparam int unsigned ROW_LSB  = 18;
    localparam int unsigned ROW_W    = 16;

    // Request op codes; anything else is illegal
    localparam logic [OP_W-1:0] OP_RD  = 2'd0;
    localparam logic [OP_W-1:0] OP_WR  = 2'd1;
    localparam logic [OP_W-1:0] OP_IF  = 2'd2;
    localparam logic [OP_W-1:0] OP_ILL = 2'd3;

    // timing_parameters: default DIMM timings in command clocks
    localparam int unsigned DEF_T_RCD   = 39;
    localparam int unsigned DEF_T_CAS   = 40;
    localparam int unsigned DEF_T_CWD   = 38;
    localparam int unsigned DEF_T_BURST = 8;
    localparam int unsigned DEF_T_WR    = 72;
    localparam int unsigned DEF_T_RAS   = 76;
    localparam int unsigned DEF_T_RP    = 39;
    localparam int unsigned DEF_CNT_W   = 8;

    // Decoded address payload
    typedef struct packed {
        logic              channel;
        logic [BG_W-1:0]   bg;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } addr_fields_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_cmd_sequencer_if.sv
// Request handshake and command/completion bus between queue, sequencer and trace writer.
interface dram_cmd_sequencer_if;
    import dram_cmd_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              cmd_valid;
    cmd_t              cmd_type;
    logic              cmd_channel;
    logic [BG_W-1:0]   cmd_bg;
    logic [BANK_W-1:0] cmd_bank;
    logic [ROW_W-1:0]  cmd_row;
    logic [COL_W-1:0]  cmd_col;
    logic              cmp_valid;
    logic              err_illegal;

    // Queue side: presents requests, observes commands
    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, cmd_valid, cmd_type, cmd_channel, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmp_valid, err_illegal
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, cmd_valid, cmd_type, cmd_channel, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmp_valid, err_illegal
    );

endinterface

// File: rtl/dram_addr_map.sv
// Combinational physical-address to DIMM coordinate decode; shared with the trace writer.
module dram_addr_map
    import dram_cmd_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output addr_fields_t      o_fields_c
);

    // Fixed bit-field extraction
    assign o_fields_c.channel = i_addr[CH_BIT];
    assign o_fields_c.bg      = i_addr[BG_LSB   +: BG_W];
    assign o_fields_c.bank    = i_addr[BANK_LSB +: BANK_W];
    assign o_fields_c.row     = i_addr[ROW_LSB  +: ROW_W];
    assign o_fields_c.col     = i_addr[COL_LSB  +: COL_W];

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: one request -> ACT0, ACT1, RD/WR pair, PRE with DIMM timing.
module dram_cmd_sequencer
    import dram_cmd_pkg::*;
#(
    parameter int unsigned T_RCD   = DEF_T_RCD,
    parameter int unsigned T_CAS   = DEF_T_CAS,
    parameter int unsigned T_CWD   = DEF_T_CWD,
    parameter int unsigned T_BURST = DEF_T_BURST,
    parameter int unsigned T_WR    = DEF_T_WR,
    parameter int unsigned T_RAS   = DEF_T_RAS,
    parameter int unsigned T_RP    = DEF_T_RP,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    dram_cmd_sequencer_if.slave bus
);

    // Offsets from ACT0 (c = 0) of completion and precharge, per direction
    localparam int unsigned CMP_RD = T_RCD + T_CAS + T_BURST;
    localparam int unsigned CMP_WR = T_RCD + T_CWD + T_BURST;
    localparam int unsigned PRE_RD = max_u(T_RAS, CMP_RD);
    localparam int unsigned PRE_WR = max_u(T_RAS, CMP_WR + T_WR);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_CAS, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cmp_tgt;
    logic [CNT_W-1:0] r_pre_tgt;
    logic [CNT_W-1:0] r_rdy_tgt;
    logic             r_is_wr;
    addr_fields_t     r_fields;
    logic             r_ready;
    logic             r_cmd_valid;
    cmd_t             r_cmd_type;
    logic             r_cmp;
    logic             r_err;

    addr_fields_t     w_fields;
    logic             w_accept;
    logic             w_is_wr;
    logic [CNT_W-1:0] w_cnt_nxt;

    dram_addr_map u_addr_map (
        .i_addr     (bus.req_addr),
        .o_fields_c (w_fields)
    );

    // Ready is only high in IDLE or on the last WAIT_RP cycle, so acceptance implies one of those
    assign w_accept  = bus.req_valid && r_ready;
    assign w_is_wr   = (bus.req_op == OP_WR);
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmp_tgt   <= '0;
            r_pre_tgt   <= '0;
            r_rdy_tgt   <= '0;
            r_is_wr     <= 1'b0;
            r_fields    <= '0;
            r_ready     <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_NOP;
            r_cmp       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_NOP;
            r_cmp       <= 1'b0;
            r_err       <= 1'b0;
            if (w_accept) begin
                r_fields <= w_fields;
                r_is_wr  <= w_is_wr;
                if (bus.req_op == OP_ILL) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_state     <= S_ACT0;
                    r_cnt       <= '0;
                    r_ready     <= 1'b0;
                    r_cmd_valid <= 1'b1;
                    r_cmd_type  <= CMD_ACT0;
                    r_cmp_tgt   <= w_is_wr ? CNT_W'(CMP_WR) : CNT_W'(CMP_RD);
                    r_pre_tgt   <= w_is_wr ? CNT_W'(PRE_WR) : CNT_W'(PRE_RD);
                    r_rdy_tgt   <= w_is_wr ? CNT_W'(PRE_WR + T_RP - 1)
                                           : CNT_W'(PRE_RD + T_RP - 1);
                end
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                    end
                    S_ACT0: begin
                        r_cnt       <= w_cnt_nxt;
                        r_state     <= S_ACT1;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= CMD_ACT1;
                    end
                    S_ACT1, S_WAIT_CAS: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == CNT_W'(T_RCD)) begin
                            r_state     <= S_CAS0;
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= r_is_wr ? CMD_WR0 : CMD_RD0;
                        end else begin
                            r_state <= S_WAIT_CAS;
                        end
                    end
                    S_CAS0: begin
                        r_cnt       <= w_cnt_nxt;
                        r_state     <= S_CAS1;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= r_is_wr ? CMD_WR1 : CMD_RD1;
                    end
                    S_CAS1, S_WAIT_PRE: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_cmp_tgt) begin
                            r_cmp <= 1'b1;
                        end
                        if (w_cnt_nxt == r_pre_tgt) begin
                            r_state     <= S_PRE;
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= CMD_PRE;
                            if (T_RP == 1) begin
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_state <= S_WAIT_PRE;
                        end
                    end
                    S_PRE: begin
                        r_cnt   <= w_cnt_nxt;
                        r_state <= S_WAIT_RP;
                        if (w_cnt_nxt == r_rdy_tgt) begin
                            r_ready <= 1'b1;
                        end
                    end
                    S_WAIT_RP: begin
                        r_cnt <= w_cnt_nxt;
                        if (r_ready) begin
                            r_state <= S_IDLE;
                        end else if (w_cnt_nxt == r_rdy_tgt) begin
                            r_ready <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_type    = r_cmd_type;
    assign bus.cmd_channel = r_fields.channel;
    assign bus.cmd_bg      = r_fields.bg;
    assign bus.cmd_bank    = r_fields.bank;
    assign bus.cmd_row     = r_fields.row;
    assign bus.cmd_col     = r_fields.col;
    assign bus.cmp_valid   = r_cmp;
    assign bus.err_illegal = r_err;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: vector table of single accesses plus reset/back-to-back sequences.
module tb_dram_cmd_sequencer;
    import dram_cmd_pkg::*;

    localparam int WIN = 230;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_cmd_sequencer_if if_a ();
    dram_cmd_sequencer_if if_b ();

    dram_cmd_sequencer u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    dram_cmd_sequencer #(.T_RAS(120)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    typedef struct packed {
        logic         rdy;
        logic         cval;
        cmd_t         ctype;
        logic         ch;
        logic [2:0]   bg;
        logic [1:0]   bank;
        logic [15:0]  row;
        logic [5:0]   col;
        logic         cmp;
        logic         err;
    } obs_t;

    // One access: stimulus plus expected sample indices (1 = first cycle after acceptance, -1 = never)
    typedef struct {
        bit          dut;
        logic [1:0]  op;
        logic [35:0] addr;
        int ch, bg, bank, row, col;
        int act0, act1, rd0, rd1, wr0, wr1, pre, cmp, rdy, ncmd, err_i;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.rdy = if_b.req_ready;  o.cval = if_b.cmd_valid; o.ctype = if_b.cmd_type;
            o.ch = if_b.cmd_channel; o.bg = if_b.cmd_bg;      o.bank = if_b.cmd_bank;
            o.row = if_b.cmd_row;    o.col = if_b.cmd_col;    o.cmp = if_b.cmp_valid;
            o.err = if_b.err_illegal;
        end else begin
            o.rdy = if_a.req_ready;  o.cval = if_a.cmd_valid; o.ctype = if_a.cmd_type;
            o.ch = if_a.cmd_channel; o.bg = if_a.cmd_bg;      o.bank = if_a.cmd_bank;
            o.row = if_a.cmd_row;    o.col = if_a.cmd_col;    o.cmp = if_a.cmp_valid;
            o.err = if_a.err_illegal;
        end
        return o;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [1:0] op, input logic [35:0] a);
        if (sel) begin
            if_b.req_valid = v; if_b.req_op = op; if_b.req_addr = a;
        end else begin
            if_a.req_valid = v; if_a.req_op = op; if_a.req_addr = a;
        end
    endtask

    // Advance to a negedge where the selected DUT shows req_ready, within a cycle budget
    task automatic wait_ready(input bit sel, input string name);
        obs_t o;
        bit   ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            o  = sample(sel);
            ok = o.rdy;
        end
        if (!ok) chk({name, ".ready_timeout"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        obs_t o;
        int act0 = -1, act1 = -1, rd0 = -1, rd1 = -1, wr0 = -1, wr1 = -1;
        int pre = -1, cmp = -1, rdy = -1, err_i = -1;
        int ncmd = 0, ncmp = 0, nerr = 0, nbad = 0;
        bit seen_low = 1'b0;
        string p = $sformatf("v%0d", idx);
        wait_ready(v.dut, p);
        drive(v.dut, 1'b1, v.op, v.addr);
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            o = sample(v.dut);
            if (i == 1) begin
                drive(v.dut, 1'b0, v.op, v.addr);
                chk({p, ".channel"}, int'(o.ch),   v.ch);
                chk({p, ".bg"},      int'(o.bg),   v.bg);
                chk({p, ".bank"},    int'(o.bank), v.bank);
                chk({p, ".row"},     int'(o.row),  v.row);
                chk({p, ".col"},     int'(o.col),  v.col);
            end
            if (o.cval) ncmd++;
            if (o.cval != (o.ctype != CMD_NOP)) nbad++;
            case (o.ctype)
                CMD_ACT0: if (act0 < 0) act0 = i;
                CMD_ACT1: if (act1 < 0) act1 = i;
                CMD_RD0:  if (rd0 < 0)  rd0 = i;
                CMD_RD1:  if (rd1 < 0)  rd1 = i;
                CMD_WR0:  if (wr0 < 0)  wr0 = i;
                CMD_WR1:  if (wr1 < 0)  wr1 = i;
                CMD_PRE:  if (pre < 0)  pre = i;
                default: ;
            endcase
            if (o.cmp) begin ncmp++; if (cmp < 0) cmp = i; end
            if (o.err) begin nerr++; if (err_i < 0) err_i = i; end
            if (!o.rdy) seen_low = 1'b1;
            else if (seen_low && rdy < 0) rdy = i;
        end
        chk({p, ".act0"}, act0, v.act0);
        chk({p, ".act1"}, act1, v.act1);
        chk({p, ".rd0"},  rd0,  v.rd0);
        chk({p, ".rd1"},  rd1,  v.rd1);
        chk({p, ".wr0"},  wr0,  v.wr0);
        chk({p, ".wr1"},  wr1,  v.wr1);
        chk({p, ".pre"},  pre,  v.pre);
        chk({p, ".cmp"},  cmp,  v.cmp);
        chk({p, ".ncmp"}, ncmp, (v.cmp < 0) ? 0 : 1);
        chk({p, ".ready_rise"}, rdy, v.rdy);
        chk({p, ".ncmd"}, ncmd, v.ncmd);
        chk({p, ".valid_vs_type"}, nbad, 0);
        chk({p, ".err_at"}, err_i, v.err_i);
        chk({p, ".nerr"}, nerr, (v.err_i < 0) ? 0 : 1);
    endtask

    localparam logic [35:0] A1 = 36'h0_1234_5C40;
    localparam logic [35:0] A2 = {2'b11, 16'hA5C3, 6'h2A, 2'd2, 3'd5, 1'b0, 6'h15};

    vec_t vecs [6];

    initial begin
        obs_t o;
        int   first, second, nrdy, ncv, ncp;

        //           dut op     addr ch bg bank row      col   act0 act1 rd0 rd1 wr0 wr1 pre  cmp rdy  ncmd err
        vecs[0] = '{1'b0, OP_RD,  A1, 1, 0, 3, 'h048D, 'h05,  1,   2,   40,  41, -1, -1,  88, 88, 126, 5,  -1};
        vecs[1] = '{1'b0, OP_WR,  A1, 1, 0, 3, 'h048D, 'h05,  1,   2,   -1,  -1, 40, 41, 158, 86, 196, 5,  -1};
        vecs[2] = '{1'b0, OP_IF,  A2, 0, 5, 2, 'hA5C3, 'h2A,  1,   2,   40,  41, -1, -1,  88, 88, 126, 5,  -1};
        vecs[3] = '{1'b0, OP_ILL, A2, 0, 5, 2, 'hA5C3, 'h2A, -1,  -1,   -1,  -1, -1, -1,  -1, -1,  -1, 0,   1};
        vecs[4] = '{1'b0, OP_RD,  A2, 0, 5, 2, 'hA5C3, 'h2A,  1,   2,   40,  41, -1, -1,  88, 88, 126, 5,  -1};
        vecs[5] = '{1'b1, OP_IF,  A1, 1, 0, 3, 'h048D, 'h05,  1,   2,   40,  41, -1, -1, 121, 88, 159, 5,  -1};

        drive(1'b0, 1'b0, 2'd0, 36'd0);
        drive(1'b1, 1'b0, 2'd0, 36'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        o = sample(1'b0);
        chk("reset.ready",   int'(o.rdy),   1);
        chk("reset.cval",    int'(o.cval),  0);
        chk("reset.ctype",   int'(o.ctype), 0);
        chk("reset.cmp",     int'(o.cmp),   0);
        chk("reset.err",     int'(o.err),   0);
        chk("reset.row",     int'(o.row),   0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Back-to-back reads with req_valid held high
        first = -1; second = -1; nrdy = 0;
        wait_ready(1'b0, "b2b");
        drive(1'b0, 1'b1, OP_RD, A1);
        for (int i = 1; i <= 300 && second < 0; i++) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.ctype == CMD_ACT0) begin
                if (first < 0) first = i;
                else second = i;
            end
            if (first >= 0 && second < 0 && o.rdy) nrdy++;
        end
        drive(1'b0, 1'b0, OP_RD, A1);
        chk("b2b.first_act0", first, 1);
        chk("b2b.act0_gap", second - first, 126);
        chk("b2b.ready_high_cycles", nrdy, 1);
        wait_ready(1'b0, "b2b_drain");

        // Reset asserted mid-WAIT_CAS
        drive(1'b0, 1'b1, OP_RD, A2);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_RD, A2);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        o = sample(1'b0);
        chk("rst_mid.ready", int'(o.rdy),  1);
        chk("rst_mid.cval",  int'(o.cval), 0);
        ncv = 0; ncp = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            o = sample(1'b0);
            if (o.cval) ncv++;
            if (o.cmp) ncp++;
        end
        chk("rst_mid.cmds_after", ncv, 0);
        chk("rst_mid.cmp_after",  ncp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
- Synthesizable downstream stage of the 16-entry memory-controller request queue.
- Pops one request at a time and issues the closed-page DDR5 command stream: ACT0, ACT1, RD0/RD1 or WR0/WR1, then PRE.
- Enforces tRCD/tCAS/tCWD/tBURST/tWR/tRAS/tRP between commands.
- Output feeds the trace-writer/DIMM model; one clk = one DIMM command clock.

Parameters:
- T_RCD, 39, ACT0 to RD0/WR0 (clk)
- T_CAS, 40, read CAS latency
- T_CWD, 38, write CAS latency
- T_BURST, 8, data burst length
- T_WR, 72, write recovery before PRE
- T_RAS, 76, minimum ACT0 to PRE
- T_RP, 39, PRE to next ACT0
- CNT_W, 8, width of the elapsed-cycle counter. All timing values must be below 2**CNT_W, and T_RCD >= 2.

Ports:
- clk  in  1  command clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  queue head valid
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0 = read, 1 = write, 2 = ifetch (treated as read), 3 = illegal
- req_addr  in  36  physical address
- cmd_valid  out  1  command issued this cycle
- cmd_type  out  3  cmd_t: NOP, ACT0, ACT1, RD0, RD1, WR0, WR1, PRE
- cmd_channel  out  1  req_addr[6]
- cmd_bg  out  3  req_addr[9:7]
- cmd_bank  out  2  req_addr[11:10]
- cmd_row  out  16  req_addr[33:18]
- cmd_col  out  6  req_addr[17:12]
- cmp_valid  out  1  one-cycle access-complete pulse
- err_illegal  out  1  one-cycle pulse when an op=3 request is accepted

Behaviour:
- Reset values: clk and one synchronous active-high reset. On rst, all outputs are 0 (cmd_type = NOP) except req_ready, which is 1. State goes to IDLE and the counter clears.
- Handshake:
  - A request is accepted on the cycle with req_valid && req_ready.
  - The address fields and op are latched at acceptance and held constant on the cmd_* outputs until the next acceptance.
  - req_valid may drop without acceptance; no state change results.
- Illegal op: an op=3 acceptance pulses err_illegal the next cycle. No commands are issued, state stays IDLE and req_ready stays 1.
- Timing frame: let c = cycles since ACT0. ACT0 is issued (registered) on the cycle after acceptance, at c=0. All outputs are registered.
- Command schedule:
  - ACT1 at c=1.
  - RD0 or WR0 at c=T_RCD; RD1 or WR1 at c=T_RCD+1.
  - PRE at c=P:
    - read: P = max(T_RAS, T_RCD+T_CAS+T_BURST)
    - write: P = max(T_RAS, T_RCD+T_CWD+T_BURST+T_WR)
  - cmp_valid pulses at c=T_RCD+T_CAS+T_BURST for a read, or c=T_RCD+T_CWD+T_BURST for a write.
  - cmd_valid is 1 only on these command cycles; on every other cycle cmd_type = NOP.
- Back-to-back: req_ready re-asserts at c=P+T_RP-1. An acceptance on that cycle puts the next ACT0 at exactly c=P+T_RP. There are no bubbles beyond tRP.
- FSM states: IDLE, ACT0, ACT1, WAIT_CAS, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP.
  - IDLE goes to ACT0 on acceptance.
  - ACT0, ACT1, CAS0 and CAS1 each last one cycle.
  - WAIT_* states exit when the counter hits the precomputed target.
  - WAIT_RP returns to ACT0 directly on acceptance at its last cycle, otherwise to IDLE.
- Counter: the CNT_W-bit counter clears at ACT0 and increments every cycle. It never wraps within one access, by the parameter constraint.
- Simultaneous events: cmp_valid and PRE may share a cycle; both are asserted.
- Reset mid-operation: the FSM aborts to IDLE on the next edge. No PRE is issued and no cmp_valid pulse occurs.

Decomposition:
- Shared package dram_cmd_pkg holds:
  - the cmd_t enum;
  - address field bit-range localparams (CH_BIT=6, BG_LSB=7, BANK_LSB=10, COL_LSB=12, ROW_LSB=18);
  - op codes OP_RD=0, OP_WR=1, OP_IF=2.
- Timing defaults are sourced from timing_parameters.
- One sub-module, dram_addr_map: combinational 36-bit address to {channel, bg, bank, row, col} decode, reused by the trace writer.

Test Plan:
- Reset: assert rst for 3 cycles mid-WAIT_CAS -> next cycle req_ready=1, cmd_valid=0, no PRE issued afterwards.
- Single read: op 0, addr 36'h0_1234_5C40 accepted at cycle 10 -> expected response:
  - ACT0 at 11, ACT1 at 12, RD0 at 50, RD1 at 51, PRE at 98, cmp_valid at 98;
  - channel=1, bg=0, bank=3, row=16'h048D, col=5.
- Single write: op 1, same address, accepted at 10 -> expected response:
  - WR0 at 50, WR1 at 51, cmp_valid at 96, PRE at 168;
  - req_ready rises at 206.
- Back-to-back reads: req_valid held high with two reads -> second ACT0 exactly 126 cycles after the first; req_ready is low in between.
- Illegal op: op 3 accepted -> err_illegal pulses for 1 cycle, no cmd_valid, req_ready stays 1, a following read proceeds normally.
- ifetch plus parameter sweep: op 2 with T_RAS=120 -> RD0/RD1 issued, PRE at c=120 rather than 87.
